// File: rtl/multicycle_control_unit_if.sv
// Control/datapath bundle for the multicycle MIPS32 control FSM.
// master = control unit (drives strobes), slave = datapath/memory side.
interface multicycle_control_unit_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pcWrite;
  logic       pcWriteCond;
  logic       iorD;
  logic       irWrite;
  logic       memRead;
  logic       memWrite;
  logic       memToReg;
  logic       regDst;
  logic       regWrite;
  logic       regWrite2;
  logic       aluSrcA;
  logic       branchNotE;
  logic       lui;
  logic       jal;
  logic [1:0] aluSrcB;
  logic [1:0] aluop;
  logic [1:0] pcSource;
  logic       instr_done;
  logic       fault;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output pcWrite, pcWriteCond, iorD, irWrite, memRead, memWrite, memToReg,
           regDst, regWrite, regWrite2, aluSrcA, branchNotE, lui, jal,
           aluSrcB, aluop, pcSource, instr_done, fault, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pcWrite, pcWriteCond, iorD, irWrite, memRead, memWrite, memToReg,
           regDst, regWrite, regWrite2, aluSrcA, branchNotE, lui, jal,
           aluSrcB, aluop, pcSource, instr_done, fault, state
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS32 main control FSM with memory-ready handshake, stall
// timeout, illegal-opcode policy and a sticky FAULT state.
module multicycle_control_unit #(
  parameter int unsigned MEM_TIMEOUT      = 15,
  parameter bit          FAULT_ON_ILLEGAL = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  multicycle_control_unit_if.master  bus
);

  localparam int unsigned CNT_W   = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned TO_LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_LUI = 6'b001111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_IMM_EXEC = 4'd10,
    S_IMM_WB   = 4'd11,
    S_FAULT    = 4'd12
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_state;
  logic             to_hit;

  // State and stall counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, Moore strobes (plus mem_ready-gated ones), stall counter
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bus.pcWrite     = 1'b0;
    bus.pcWriteCond = 1'b0;
    bus.iorD        = 1'b0;
    bus.irWrite     = 1'b0;
    bus.memRead     = 1'b0;
    bus.memWrite    = 1'b0;
    bus.memToReg    = 1'b0;
    bus.regDst      = 1'b0;
    bus.regWrite    = 1'b0;
    bus.regWrite2   = 1'b0;
    bus.aluSrcA     = 1'b0;
    bus.branchNotE  = 1'b0;
    bus.lui         = 1'b0;
    bus.jal         = 1'b0;
    bus.aluSrcB     = 2'b00;
    bus.aluop       = 2'b00;
    bus.pcSource    = 2'b00;
    bus.instr_done  = 1'b0;
    bus.fault       = 1'b0;
    bus.state       = 4'd0;

    mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    to_hit    = (MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST)) && !bus.mem_ready;

    // Reset forces every output low, including partial writeback strobes
    if (!rst) begin
      bus.state = 4'(state_q);
      case (state_q)
        S_FETCH: begin
          bus.memRead = 1'b1;
          bus.aluSrcB = 2'b01;
          if (bus.mem_ready) begin
            bus.irWrite = 1'b1;
            bus.pcWrite = 1'b1;
            state_d     = S_DECODE;
          end else if (to_hit) begin
            state_d = S_FAULT;
          end
        end
        S_DECODE: begin
          bus.aluSrcB = 2'b11;
          case (bus.opcode)
            OP_LW, OP_SW:   state_d = S_MEM_ADDR;
            OP_R:           state_d = S_EXEC;
            OP_BEQ, OP_BNE: state_d = S_BRANCH;
            OP_J, OP_JAL:   state_d = S_JUMP;
            OP_ORI, OP_LUI: state_d = S_IMM_EXEC;
            default: begin
              if (FAULT_ON_ILLEGAL) begin
                state_d = S_FAULT;
              end else begin
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
              end
            end
          endcase
        end
        S_MEM_ADDR: begin
          bus.aluSrcA = 1'b1;
          bus.aluSrcB = 2'b10;
          state_d     = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          bus.memRead = 1'b1;
          bus.iorD    = 1'b1;
          if (bus.mem_ready)  state_d = S_MEM_WB;
          else if (to_hit)    state_d = S_FAULT;
        end
        S_MEM_WB: begin
          bus.regWrite   = 1'b1;
          bus.memToReg   = 1'b1;
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
        end
        S_MEM_WR: begin
          bus.memWrite   = 1'b1;
          bus.iorD       = 1'b1;
          bus.instr_done = bus.mem_ready;
          if (bus.mem_ready)  state_d = S_FETCH;
          else if (to_hit)    state_d = S_FAULT;
        end
        S_EXEC: begin
          bus.aluSrcA = 1'b1;
          bus.aluop   = 2'b10;
          state_d     = S_ALU_WB;
        end
        S_ALU_WB: begin
          bus.regDst     = 1'b1;
          bus.regWrite   = 1'b1;
          bus.regWrite2  = 1'b1;
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
        end
        S_BRANCH: begin
          bus.aluSrcA     = 1'b1;
          bus.aluop       = 2'b01;
          bus.pcWriteCond = 1'b1;
          bus.pcSource    = 2'b01;
          bus.branchNotE  = (bus.opcode == OP_BNE);
          bus.instr_done  = 1'b1;
          state_d         = S_FETCH;
        end
        S_JUMP: begin
          bus.pcWrite    = 1'b1;
          bus.pcSource   = 2'b10;
          bus.jal        = (bus.opcode == OP_JAL);
          bus.regWrite   = (bus.opcode == OP_JAL);
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
        end
        S_IMM_EXEC: begin
          bus.aluSrcA = 1'b1;
          bus.aluSrcB = 2'b10;
          bus.aluop   = 2'b11;
          bus.lui     = (bus.opcode == OP_LUI);
          state_d     = S_IMM_WB;
        end
        S_IMM_WB: begin
          bus.regWrite   = 1'b1;
          bus.lui        = (bus.opcode == OP_LUI);
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
        end
        S_FAULT: begin
          bus.fault = 1'b1;
        end
        default: begin
          state_d = S_FAULT;
        end
      endcase
    end

    // Stall counter restarts on every state change and saturates
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (mem_state && !bus.mem_ready && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

endmodule
